// File: rtl/ldl_rr_grant_mux.sv
// ldl_rr_grant_mux: takes the arbiter's grant and selects the winner's class and payload.
// It buffers them in a 2-entry skid FIFO toward a ready/valid sink.
// It also keeps saturating per-requester grant counters for debug readback.
module ldl_rr_grant_mux #(
  parameter int BIN_WIDTH  = 3,
  parameter int REQ_WIDTH  = 1 << BIN_WIDTH,
  parameter int COS_WIDTH  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 valid,
  input  logic [BIN_WIDTH-1:0]                 bin,
  output logic                                 ready,
  input  logic [REQ_WIDTH-1:0][COS_WIDTH-1:0]  cos,
  input  logic [REQ_WIDTH-1:0][DATA_WIDTH-1:0] data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [BIN_WIDTH-1:0]                 out_bin,
  output logic [COS_WIDTH-1:0]                 out_cos,
  output logic [DATA_WIDTH-1:0]                out_data,
  input  logic [BIN_WIDTH-1:0]                 stat_sel,
  input  logic                                 stat_clr,
  output logic [CNT_WIDTH-1:0]                 stat_cnt
);

  // FIFO state: two entries addressed by 1-bit read/write pointers plus a fill count.
  logic [1:0]            fill_q, fill_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [BIN_WIDTH-1:0]  ent_bin_q  [2];
  logic [BIN_WIDTH-1:0]  ent_bin_d  [2];
  logic [COS_WIDTH-1:0]  ent_cos_q  [2];
  logic [COS_WIDTH-1:0]  ent_cos_d  [2];
  logic [DATA_WIDTH-1:0] ent_data_q [2];
  logic [DATA_WIDTH-1:0] ent_data_d [2];
  logic [CNT_WIDTH-1:0]  stat_cnt_q, stat_cnt_d;
  logic [CNT_WIDTH-1:0]  gcnt_rd [REQ_WIDTH];
  logic                  push;
  logic                  pop;

  // ready depends only on the fill count, so there is no combinational path from out_ready or valid.
  assign ready     = (fill_q != 2'd2);
  assign out_valid = (fill_q != 2'd0);
  assign push      = valid && ready;
  assign pop       = out_valid && out_ready;
  assign out_bin   = ent_bin_q[rd_ptr_q];
  assign out_cos   = ent_cos_q[rd_ptr_q];
  assign out_data  = ent_data_q[rd_ptr_q];
  assign stat_cnt  = stat_cnt_q;

  // Next-state for the FIFO: write the tail on push, advance the head on pop.
  always_comb begin
    ent_bin_d  = ent_bin_q;
    ent_cos_d  = ent_cos_q;
    ent_data_d = ent_data_q;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    fill_d     = fill_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      ent_bin_d[wr_ptr_q]  = bin;
      ent_cos_d[wr_ptr_q]  = cos[bin];
      ent_data_d[wr_ptr_q] = data[bin];
    end
  end

  // FIFO registers; reset empties the buffer immediately and zeroes the visible head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q   <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        ent_bin_q[i]  <= '0;
        ent_cos_q[i]  <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      fill_q     <= fill_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      ent_bin_q  <= ent_bin_d;
      ent_cos_q  <= ent_cos_d;
      ent_data_q <= ent_data_d;
    end
  end

  // One saturating grant counter per requester; a clear beats a coincident grant.
  for (genvar gi = 0; gi < REQ_WIDTH; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] c_q, c_d;

    // Next counter value: clear, saturating increment on a grant to this requester, or hold.
    always_comb begin
      c_d = c_q;
      if (stat_clr) begin
        c_d = '0;
      end else if (push && (bin == BIN_WIDTH'(gi)) && (c_q != {CNT_WIDTH{1'b1}})) begin
        c_d = c_q + 1'b1;
      end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) c_q <= '0;
      else        c_q <= c_d;
    end

    assign gcnt_rd[gi] = c_q;
  end

  // Readback samples the selected counter as it stands before the edge.
  always_comb begin
    stat_cnt_d = gcnt_rd[stat_sel];
  end

  // Readback register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_cnt_q <= '0;
    else        stat_cnt_q <= stat_cnt_d;
  end

endmodule

// File: tb/tb_ldl_rr_grant_mux.sv
// Bench for ldl_rr_grant_mux: directed scenarios followed by random traffic.
// A queue-based model of the FIFO and counters is compared against the DUT every cycle.
module tb_ldl_rr_grant_mux;
  localparam int BW = 3;
  localparam int RW = 8;
  localparam int CW = 2;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int CMAX = (1 << NW) - 1;

  logic                  clk;
  logic                  rst_n;
  logic                  valid;
  logic [BW-1:0]         bin;
  logic                  ready;
  logic [RW-1:0][CW-1:0] cos;
  logic [RW-1:0][DW-1:0] data;
  logic                  out_valid;
  logic                  out_ready;
  logic [BW-1:0]         out_bin;
  logic [CW-1:0]         out_cos;
  logic [DW-1:0]         out_data;
  logic [BW-1:0]         stat_sel;
  logic                  stat_clr;
  logic [NW-1:0]         stat_cnt;

  ldl_rr_grant_mux #(
    .BIN_WIDTH(BW), .COS_WIDTH(CW), .DATA_WIDTH(DW), .CNT_WIDTH(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .bin(bin), .ready(ready),
    .cos(cos), .data(data), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_cos(out_cos), .out_data(out_data),
    .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] b;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t     mq[$];
  int       mcnt[RW];
  int       stat_exp;
  int       checks = 0;
  int       errors = 0;
  bit       chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < RW; i++) mcnt[i] = 0;
    stat_exp = 0;
  endtask

  // Model one rising edge using the inputs presented during the cycle.
  task automatic model_update();
    bit   do_push;
    bit   do_pop;
    ent_t e;
    do_push  = valid && (mq.size() < 2);
    do_pop   = out_ready && (mq.size() != 0);
    stat_exp = mcnt[stat_sel];
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      e.b = bin;
      e.c = cos[bin];
      e.d = data[bin];
      mq.push_back(e);
    end
    if (stat_clr) begin
      for (int i = 0; i < RW; i++) mcnt[i] = 0;
    end else if (do_push && mcnt[bin] < CMAX) begin
      mcnt[bin] = mcnt[bin] + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 64'(ready), 64'(mq.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("out_bin", 64'(out_bin), 64'(mq[0].b));
        chk("out_cos", 64'(out_cos), 64'(mq[0].c));
        chk("out_data", 64'(out_data), 64'(mq[0].d));
      end
      chk("stat_cnt", 64'(stat_cnt), 64'(stat_exp));
    end
  end

  initial begin
    int bp[3];
    int st[4];
    rst_n = 1'b0; valid = 1'b0; bin = '0; out_ready = 1'b0;
    stat_sel = '0; stat_clr = 1'b0;
    for (int i = 0; i < RW; i++) begin
      cos[i]  = CW'(i);
      data[i] = 32'hA5A5_0000 | i;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state.
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    for (int s = 0; s < RW; s++) begin
      stat_sel = BW'(s);
      tick();
      chk("rst_stat_cnt", 64'(stat_cnt), 64'd0);
    end

    // Single grant to requester 5.
    cos[5] = 2'd2; data[5] = 32'hA5A5_0005;
    out_ready = 1'b1; valid = 1'b1; bin = 3'd5;
    tick();
    valid = 1'b0;
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_bin", 64'(out_bin), 64'd5);
    chk("single_cos", 64'(out_cos), 64'd2);
    chk("single_data", 64'(out_data), 64'hA5A5_0005);
    tick();
    stat_sel = 3'd5;
    tick();
    chk("single_stat", 64'(stat_cnt), 64'd1);

    // Streaming at full rate.
    st = '{0, 2, 5, 7};
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1; bin = BW'(st[k]);
      tick();
      chk("stream_bin", 64'(out_bin), 64'(st[k]));
      chk("stream_ready", 64'(ready), 64'd1);
    end
    valid = 1'b0;
    tick();

    // Back-pressure with three grants offered.
    out_ready = 1'b0;
    bp = '{1, 3, 6};
    valid = 1'b1; bin = BW'(bp[0]); tick();
    bin = BW'(bp[1]); tick();
    chk("bp_ready_low", 64'(ready), 64'd0);
    bin = BW'(bp[2]); tick();
    chk("bp_hold_ready", 64'(ready), 64'd0);
    chk("bp_head", 64'(out_bin), 64'd1);
    out_ready = 1'b1; tick();
    chk("bp_drain1", 64'(out_bin), 64'd3);
    chk("bp_ready_back", 64'(ready), 64'd1);
    tick();
    valid = 1'b0;
    chk("bp_drain2", 64'(out_bin), 64'd6);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Saturating counter: 20 grants to requester 4.
    valid = 1'b1; bin = 3'd4;
    repeat (20) tick();
    valid = 1'b0; stat_sel = 3'd4;
    tick();
    chk("sat_stat", 64'(stat_cnt), 64'd15);

    // Clear coinciding with a push: the clear wins.
    valid = 1'b1; bin = 3'd4; stat_clr = 1'b1;
    tick();
    valid = 1'b0; stat_clr = 1'b0;
    tick();
    chk("clr_stat", 64'(stat_cnt), 64'd0);
    tick();

    // Asynchronous reset with the FIFO full.
    out_ready = 1'b0; valid = 1'b1; bin = 3'd2; tick();
    bin = 3'd3; tick();
    valid = 1'b0;
    chk("pre_rst_ready", 64'(ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_ready", 64'(ready), 64'd1);
    chk("arst_out_bin", 64'(out_bin), 64'd0);
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1; valid = 1'b1; bin = 3'd7;
    tick();
    valid = 1'b0;
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_bin", 64'(out_bin), 64'd7);
    stat_sel = 3'd2;
    tick();
    tick();
    chk("post_rst_stat", 64'(stat_cnt), 64'd0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      valid     = ($urandom_range(0, 3) != 0);
      bin       = BW'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      stat_sel  = BW'($urandom);
      stat_clr  = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < RW; i++) begin
        cos[i]  = CW'($urandom);
        data[i] = $urandom;
      end
      tick();
    end
    valid = 1'b0; stat_clr = 1'b0;
    tick();

    @(posedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
